pe_link_packer: RTL

PE_LINK_PACKER -- requirements
Module: pe_link_packer

---
 rtl/pe_link_packer_pkg.sv | 21 ++
 rtl/pe_lane_buffer.sv | 49 ++++
 rtl/pe_link_packer.sv | 76 +++++++
 3 files changed

// File: rtl/pe_link_packer_pkg.sv
// rtl/pe_link_packer_pkg.sv - shared link word layout and packer FSM states
package pe_link_packer_pkg;

  // Link word layout shared by every link-facing PE tile
  localparam int PE_LINK_WIDTH    = 130;
  localparam int PE_VALID_BIT     = 129;
  localparam int PE_LAST_BIT      = 128;
  localparam int PE_PAYLOAD_WIDTH = 128;

  // IDLE: no lane held; FILL: at least one lane held
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } link_state_e;

  // Lane index width, kept at least one bit so a single-lane build still elaborates
  function automatic int lane_idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/pe_lane_buffer.sv
// rtl/pe_lane_buffer.sv - lane buffer and lane counter for the link packer
module pe_lane_buffer
  import pe_link_packer_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int LANES    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic                      clear,
  input  logic [IN_WIDTH-1:0]       wr_data,
  output logic                      lane_last,
  output logic [IN_WIDTH*LANES-1:0] merged
);

  localparam int IDX_W = lane_idx_width(LANES);

  logic [IN_WIDTH*LANES-1:0] lanes_q;
  logic [IDX_W-1:0]          idx_q;

  // The word being written lands in the current lane; this is the final lane when set
  assign lane_last = (idx_q == IDX_W'(LANES - 1));

  // Held lanes with this cycle's word merged in, so an emit can include it directly
  always_comb begin
    merged = lanes_q;
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && (idx_q == IDX_W'(i))) begin
        merged[i*IN_WIDTH +: IN_WIDTH] = wr_data;
      end
    end
  end

  // Clear on emit wins over a write so unwritten lanes of the next word start at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else if (wr_en) begin
      lanes_q <= merged;
      idx_q   <= lane_last ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/pe_link_packer.sv
// rtl/pe_link_packer.sv - packs narrow stream words into valid/last-tagged link words
module pe_link_packer
  import pe_link_packer_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int LANES      = 4,
  parameter int LINK_WIDTH = PE_LINK_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [LINK_WIDTH-1:0] out_to_north,
  output logic [15:0]           out_words
);

  link_state_e               state_q;
  logic [LINK_WIDTH-1:0]     out_q;
  logic [15:0]               words_q;
  logic                      accept;
  logic                      force_last;
  logic                      lane_last;
  logic                      accept_emit;
  logic                      flush_emit;
  logic                      emit;
  logic [IN_WIDTH*LANES-1:0] merged;

  assign in_ready     = ap_start;
  assign accept       = in_valid & ap_start;
  // A flush riding on an accept closes the packet just like in_last
  assign force_last   = in_last | flush;
  assign accept_emit  = accept & (lane_last | force_last);
  // A lone flush only matters when something is buffered
  assign flush_emit   = ap_start & flush & ~accept & (state_q == ST_FILL);
  assign emit         = accept_emit | flush_emit;

  assign out_to_north = out_q;
  assign out_words    = words_q;

  pe_lane_buffer #(
    .IN_WIDTH (IN_WIDTH),
    .LANES    (LANES)
  ) u_lanes (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (accept),
    .clear     (emit),
    .wr_data   (in_data),
    .lane_last (lane_last),
    .merged    (merged)
  );

  // FSM, registered link word and emit counter; valid pulses for one cycle, the rest holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      words_q <= '0;
    end else begin
      out_q[PE_VALID_BIT] <= emit;
      if (emit) begin
        out_q[PE_LAST_BIT]                <= accept_emit ? force_last : 1'b1;
        out_q[PE_PAYLOAD_WIDTH-1:0]       <= merged;
        words_q                           <= words_q + 16'd1;
        state_q                           <= ST_IDLE;
      end else if (accept) begin
        state_q <= ST_FILL;
      end
    end
  end

endmodule
